branch_resolve_unit: RTL and testbench

//  Decode-stage resolver that closes the loop with the fetch-stage dynamic predictor.
//  - Carries the IF-stage prediction across the IF/ID boundary and evaluates the real B/BR outcome.
//  - Drives the predictor update bus: was_branch, actual_taken, actual_target, branch_mispredicted.
//  - On a misprediction, issues the fetch redirect and flushes the wrong-path IF/ID slot.
//  - Keeps saturating branch and mispredict counters.

---
 rtl/branch_resolve_unit.sv | 173 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Decode-stage branch resolver: carries the fetch-stage prediction into decode, resolves B/BR,
// drives the predictor update bus and fetch redirect, and keeps saturating branch statistics.
module branch_resolve_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_IF_ID,
    input  logic             pred_taken_IF,
    input  logic [15:0]      pred_target_IF,
    input  logic             instr_valid_IF,
    input  logic [15:0]      instr_ID,
    input  logic [15:0]      pc_next_ID,
    input  logic [15:0]      rs_data_ID,
    input  logic [2:0]       flags_ZVN,
    input  logic             flags_pending,
    output logic             was_branch,
    output logic             actual_taken,
    output logic [15:0]      actual_target,
    output logic             branch_mispredicted,
    output logic             redirect_en,
    output logic [15:0]      redirect_pc,
    output logic             flush_IF_ID,
    output logic             stall_req,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispred_count,
    output logic [1:0]       dbg_state
);

    // dbg_state encoding: 0 = RUN, 1 = WAIT_F, 2 = FLUSH
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        WAIT_F = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             pred_taken_q, pred_taken_d;
    logic [15:0]      pred_target_q, pred_target_d;
    logic             valid_q, valid_d;
    logic             resolved_q, resolved_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [3:0]  opcode;
    logic [2:0]  ccc;
    logic        flag_z, flag_v, flag_n;
    logic        is_br_reg;
    logic        is_branch;
    logic [15:0] b_offset;
    logic [15:0] target;
    logic        cond_true;
    logic        mispred;
    logic        resolve;
    logic        stall_c;
    logic        mis_fire;
    logic        load_en;

    assign opcode    = instr_ID[15:12];
    assign ccc       = instr_ID[11:9];
    assign {flag_z, flag_v, flag_n} = flags_ZVN;
    assign is_br_reg = (opcode == 4'b1101);
    assign is_branch = valid_q & ((opcode == 4'b1100) | is_br_reg);
    assign b_offset  = {{6{instr_ID[8]}}, instr_ID[8:0], 1'b0};
    assign target    = is_br_reg ? rs_data_ID : (pc_next_ID + b_offset);

    always_comb begin
        cond_true = 1'b0;
        case (ccc)
            3'b000:  cond_true = ~flag_z;
            3'b001:  cond_true = flag_z;
            3'b010:  cond_true = ~flag_z & ~flag_n;
            3'b011:  cond_true = flag_n;
            3'b100:  cond_true = flag_z | (~flag_z & ~flag_n);
            3'b101:  cond_true = flag_n | flag_z;
            3'b110:  cond_true = flag_v;
            default: cond_true = 1'b1;
        endcase
    end

    // A target mismatch only matters when both sides agree the branch is taken.
    assign mispred = (pred_taken_q != cond_true)
                   | (pred_taken_q & cond_true & (pred_target_q != target));

    always_comb begin
        state_d = state_q;
        resolve = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            RUN: begin
                if (is_branch && !resolved_q) begin
                    if (flags_pending && (ccc != 3'b111)) begin
                        stall_c = 1'b1;
                        state_d = WAIT_F;
                    end else begin
                        resolve = 1'b1;
                        if (mispred) state_d = FLUSH;
                    end
                end
            end
            WAIT_F: begin
                if (flags_pending) begin
                    stall_c = 1'b1;
                end else begin
                    resolve = 1'b1;
                    state_d = mispred ? FLUSH : RUN;
                end
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign mis_fire = resolve & mispred;
    // Flush overrides both stall sources so the wrong-path slot is always killed.
    assign load_en  = mis_fire | ~(stall_IF_ID | stall_c);

    always_comb begin
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        valid_d       = valid_q;
        resolved_d    = resolved_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (mis_fire) begin
            pred_taken_d  = 1'b0;
            pred_target_d = 16'h0000;
            valid_d       = 1'b0;
        end else if (load_en) begin
            pred_taken_d  = pred_taken_IF;
            pred_target_d = pred_target_IF;
            valid_d       = instr_valid_IF;
        end
        if (load_en)      resolved_d = 1'b0;
        else if (resolve) resolved_d = 1'b1;
        if (resolve && !(&branch_cnt_q))   branch_cnt_d  = branch_cnt_q + CNT_W'(1);
        if (mis_fire && !(&mispred_cnt_q)) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            pred_taken_q  <= 1'b0;
            pred_target_q <= 16'h0000;
            valid_q       <= 1'b0;
            resolved_q    <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            valid_q       <= valid_d;
            resolved_q    <= resolved_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Outputs are forced quiet while rst is high so nothing leaks from a pre-reset state.
    assign was_branch          = ~rst & resolve;
    assign actual_taken        = ~rst & resolve & cond_true;
    assign actual_target       = (~rst & resolve) ? target : 16'h0000;
    assign branch_mispredicted = ~rst & mis_fire;
    assign redirect_en         = ~rst & mis_fire;
    assign flush_IF_ID         = ~rst & mis_fire;
    assign redirect_pc         = (~rst & mis_fire) ? (cond_true ? target : pc_next_ID) : 16'h0000;
    assign stall_req           = ~rst & stall_c;
    assign branch_count        = rst ? '0 : branch_cnt_q;
    assign mispred_count       = rst ? '0 : mispred_cnt_q;
    assign dbg_state           = rst ? RUN : state_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized branch episodes compared
// against a transaction-level model of condition codes, targets, mispredicts and counters.
module tb_branch_resolve_unit;

    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             stall_IF_ID;
    logic             pred_taken_IF;
    logic [15:0]      pred_target_IF;
    logic             instr_valid_IF;
    logic [15:0]      instr_ID;
    logic [15:0]      pc_next_ID;
    logic [15:0]      rs_data_ID;
    logic [2:0]       flags_ZVN;
    logic             flags_pending;
    logic             was_branch;
    logic             actual_taken;
    logic [15:0]      actual_target;
    logic             branch_mispredicted;
    logic             redirect_en;
    logic [15:0]      redirect_pc;
    logic             flush_IF_ID;
    logic             stall_req;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispred_count;
    logic [1:0]       dbg_state;

    branch_resolve_unit #(.CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall_IF_ID         (stall_IF_ID),
        .pred_taken_IF       (pred_taken_IF),
        .pred_target_IF      (pred_target_IF),
        .instr_valid_IF      (instr_valid_IF),
        .instr_ID            (instr_ID),
        .pc_next_ID          (pc_next_ID),
        .rs_data_ID          (rs_data_ID),
        .flags_ZVN           (flags_ZVN),
        .flags_pending       (flags_pending),
        .was_branch          (was_branch),
        .actual_taken        (actual_taken),
        .actual_target       (actual_target),
        .branch_mispredicted (branch_mispredicted),
        .redirect_en         (redirect_en),
        .redirect_pc         (redirect_pc),
        .flush_IF_ID         (flush_IF_ID),
        .stall_req           (stall_req),
        .branch_count        (branch_count),
        .mispred_count       (mispred_count),
        .dbg_state           (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;
    int m_branch     = 0;
    int m_mispred    = 0;
    logic [37:0] exp_q[$];

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [37:0] obs_bus();
        return {was_branch, actual_taken, actual_target, branch_mispredicted,
                redirect_en, redirect_pc, flush_IF_ID, stall_req};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic ref_taken(input logic [2:0] ccc, input logic [2:0] zvn);
        logic z, v, n;
        z = zvn[2]; v = zvn[1]; n = zvn[0];
        case (ccc)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] ref_target(input logic [15:0] instr, input logic [15:0] pc,
                                               input logic [15:0] rs);
        int off;
        int sum;
        if (instr[15:12] == 4'hD) return rs;
        off = int'(instr[8:0]);
        if (off >= 256) off = off - 512;
        sum = int'(pc) + off * 2;
        return sum[15:0];
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, "_bcnt"}, 40'(branch_count), 40'(m_branch));
        check_eq({tag, "_mcnt"}, 40'(mispred_count), 40'(m_mispred));
    endtask

    // Load a prediction in IF, then present the instruction in decode and follow it to completion.
    task automatic run_episode(input logic [15:0] instr, input logic [15:0] pc, input logic [15:0] rs,
                               input logic [2:0] zvn, input logic p_taken, input logic [15:0] p_target,
                               input int pend, input int hold);
        logic        is_br_op, t, mis;
        logic [15:0] tgt, rpc;
        logic [2:0]  ccc;

        pred_taken_IF  = p_taken;
        pred_target_IF = p_target;
        instr_valid_IF = 1'b1;
        stall_IF_ID    = 1'b0;
        flags_pending  = 1'b0;
        instr_ID       = 16'($urandom);
        pc_next_ID     = 16'($urandom);
        rs_data_ID     = 16'($urandom);
        @(negedge clk);
        check_eq("bubble_idle", 40'(obs_bus()), 40'd0);
        step();

        instr_valid_IF = 1'b0;
        pred_taken_IF  = 1'($urandom);
        pred_target_IF = 16'($urandom);
        instr_ID       = instr;
        pc_next_ID     = pc;
        rs_data_ID     = rs;
        is_br_op       = (instr[15:12] == 4'hC) || (instr[15:12] == 4'hD);
        ccc            = instr[11:9];

        if (!is_br_op) begin
            flags_pending = 1'($urandom_range(0, 1));
            flags_ZVN     = zvn;
            @(negedge clk);
            check_eq("nonbranch_idle", 40'(obs_bus()), 40'd0);
            step();
            flags_pending = 1'b0;
            check_counters("nonbranch");
            return;
        end

        t   = ref_taken(ccc, zvn);
        tgt = ref_target(instr, pc, rs);
        mis = (p_taken != t) || (p_taken && t && (p_target != tgt));
        rpc = mis ? (t ? tgt : pc) : 16'h0000;

        if (ccc != 3'b111) begin
            for (int i = 0; i < pend; i++) begin
                flags_pending = 1'b1;
                flags_ZVN     = 3'($urandom);
                stall_IF_ID   = 1'($urandom_range(0, 1));
                @(negedge clk);
                check_eq("pending_stall", 40'(obs_bus()), 40'd1);
                check_eq("pending_state", 40'(dbg_state), (i == 0) ? 40'd0 : 40'd1);
                step();
            end
        end

        flags_pending = (ccc == 3'b111) && (pend > 0);
        flags_ZVN     = zvn;
        stall_IF_ID   = (hold > 0);
        exp_q.push_back({1'b1, t, tgt, mis, mis, rpc, mis, 1'b0});
        @(negedge clk);
        check_eq("resolve_bus", 40'(obs_bus()), 40'(exp_q.pop_front()));
        step();
        m_branch = sat_inc(m_branch);
        if (mis) m_mispred = sat_inc(m_mispred);
        flags_pending = 1'b0;

        if (mis) begin
            stall_IF_ID = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("flush_idle", 40'(obs_bus()), 40'd0);
            check_eq("flush_state", 40'(dbg_state), 40'd2);
            step();
            stall_IF_ID = 1'b0;
        end else begin
            for (int h = 1; h <= hold; h++) begin
                stall_IF_ID = (h < hold);
                @(negedge clk);
                check_eq("held_silent", 40'(obs_bus()), 40'd0);
                step();
            end
        end
        check_counters("episode");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] instr, pc, rs, ptgt;
        logic [2:0]  zvn;
        logic        ptk;

        rst = 1'b1; stall_IF_ID = 1'b0; pred_taken_IF = 1'b0; pred_target_IF = 16'h0;
        instr_valid_IF = 1'b0; instr_ID = 16'h0; pc_next_ID = 16'h0; rs_data_ID = 16'h0;
        flags_ZVN = 3'b000; flags_pending = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("reset_bus", 40'(obs_bus()), 40'd0);
            step();
        end
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_reset_bus", 40'(obs_bus()), 40'd0);
        check_eq("post_reset_state", 40'(dbg_state), 40'd0);
        check_counters("post_reset");
        step();

        // B EQ taken, correct prediction; then predicted not-taken; then BR UN target mismatch
        run_episode(16'hC204, 16'h0010, 16'h0000, 3'b100, 1'b1, 16'h0018, 0, 0);
        run_episode(16'hC204, 16'h0010, 16'h0000, 3'b100, 1'b0, 16'h0000, 0, 0);
        run_episode(16'hDE00, 16'h0200, 16'h1234, 3'b000, 1'b1, 16'h1230, 0, 0);
        // B NE waiting on flags for three cycles, correctly predicted, decode held afterwards
        run_episode(16'hC004, 16'h0100, 16'h0000, 3'b000, 1'b1, 16'h0108, 3, 2);
        // Backward branch with a negative offset, UN with flags pending resolves immediately
        run_episode(16'hCFFE, 16'h0004, 16'h0000, 3'b000, 1'b1, 16'h0000, 2, 0);

        // Reset while waiting on flags
        run_episode(16'h0123, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0, 0, 0);
        pred_taken_IF = 1'b1; pred_target_IF = 16'h0108; instr_valid_IF = 1'b1;
        step();
        instr_valid_IF = 1'b0; instr_ID = 16'hC004; pc_next_ID = 16'h0100; flags_pending = 1'b1;
        @(negedge clk);
        check_eq("rstwait_stall", 40'(obs_bus()), 40'd1);
        step();
        @(negedge clk);
        check_eq("rstwait_state", 40'(dbg_state), 40'd1);
        step();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rstwait_bus", 40'(obs_bus()), 40'd0);
            check_eq("rstwait_cnt", 40'({branch_count, mispred_count}), 40'd0);
            step();
        end
        rst = 1'b0; flags_pending = 1'b0;
        m_branch = 0; m_mispred = 0;
        @(negedge clk);
        check_eq("after_rst_bus", 40'(obs_bus()), 40'd0);
        check_eq("after_rst_state", 40'(dbg_state), 40'd0);
        check_counters("after_rst");
        step();

        // Randomized episodes
        for (int n = 0; n < 300; n++) begin
            instr = 16'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: instr[15:12] = 4'hC;
                4, 5, 6:    instr[15:12] = 4'hD;
                default:    ;
            endcase
            pc   = 16'($urandom);
            rs   = 16'($urandom);
            zvn  = 3'($urandom);
            ptk  = 1'($urandom);
            ptgt = ($urandom_range(0, 1) == 1) ? ref_target(instr, pc, rs) : 16'($urandom);
            run_episode(instr, pc, rs, zvn, ptk, ptgt, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Drive both counters into saturation with unconditional mispredicts
        for (int n = 0; n < CMAX + 20; n++) begin
            run_episode(16'hDE00, 16'($urandom), 16'($urandom | 1), 3'($urandom), 1'b0, 16'h0, 0, 0);
        end
        check_eq("sat_branch", 40'(branch_count), 40'(CMAX));
        check_eq("sat_mispred", 40'(mispred_count), 40'(CMAX));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
